// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the core decoder.
//   op_type_t   : 3-bit major opcode, OP_A..OP_H (OP_E and OP_H are reserved)
//   func3_d_t   : subtypes of op D (CLIR, CUIR, JLL)
//   func3_f_t   : subtypes of op F (LDM, JLRL)
//   err_code_t  : encoder error codes
//   *_LSB/*_MSB : bit positions of the fields inside the 32-bit word
package isa_pkg;

   typedef enum logic [2:0] {
      OP_A = 3'd0,
      OP_B = 3'd1,
      OP_C = 3'd2,
      OP_D = 3'd3,
      OP_E = 3'd4,
      OP_F = 3'd5,
      OP_G = 3'd6,
      OP_H = 3'd7
   } op_type_t;

   typedef enum logic [2:0] {
      D_CLIR = 3'd0,
      D_CUIR = 3'd1,
      D_JLL  = 3'd2
   } func3_d_t;

   typedef enum logic [2:0] {
      F_LDM  = 3'd0,
      F_JLRL = 3'd1
   } func3_f_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_ILLEGAL_OP = 2'd1,
      ERR_IMM_RANGE  = 2'd2,
      ERR_OVERFLOW   = 2'd3
   } err_code_t;

   localparam int OP_LSB    = 0;
   localparam int OP_MSB    = 2;
   localparam int F3_LSB    = 3;
   localparam int F3_MSB    = 5;
   localparam int RD_LSB    = 6;
   localparam int RD_MSB    = 10;
   localparam int RS1_LSB   = 11;
   localparam int RS1_MSB   = 15;
   localparam int RS2_LSB   = 16;
   localparam int RS2_MSB   = 20;
   localparam int F11_LSB   = 21;
   localparam int F11_MSB   = 31;
   localparam int IMM16_LSB = 16;
   localparam int IMM16_MSB = 31;
   localparam int IMM21_LSB = 11;
   localparam int IMM21_MSB = 31;

   function automatic logic op_is_reserved(logic [2:0] op);
      return (op == OP_E) || (op == OP_H);
   endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational field-to-word packer with immediate range flags.
//   op, func3, rd, rs1, rs2, func11, imm : instruction fields
//   word       : packed 32-bit ISA word (unused fields zero)
//   op_illegal : op is reserved (E or H)
//   range_fail : immediate does not fit its field
// Build option: INSTR_ENC_RANGE_CHECK_EN enables the immediate range checks;
// without it range_fail is tied low and immediates are truncated.
module instr_packer
   import isa_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [2:0]  func3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [10:0] func11,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        op_illegal,
   output logic        range_fail
);

   always_comb begin
      word                   = '0;
      word[OP_MSB:OP_LSB]    = op;
      word[F3_MSB:F3_LSB]    = func3;
      op_illegal             = op_is_reserved(op);
      case (op_type_t'(op))
         OP_A: begin
            word[RD_MSB:RD_LSB]   = rd;
            word[RS1_MSB:RS1_LSB] = rs1;
            word[RS2_MSB:RS2_LSB] = rs2;
            word[F11_MSB:F11_LSB] = func11;
         end
         OP_B, OP_F: begin
            word[RD_MSB:RD_LSB]       = rd;
            word[RS1_MSB:RS1_LSB]     = rs1;
            word[IMM16_MSB:IMM16_LSB] = imm[15:0];
         end
         OP_C: begin
            // store-like split immediate: low 5 bits sit where rd would be
            word[RD_MSB:RD_LSB]   = imm[4:0];
            word[RS1_MSB:RS1_LSB] = rs1;
            word[RS2_MSB:RS2_LSB] = rs2;
            word[F11_MSB:F11_LSB] = imm[15:5];
         end
         OP_D: begin
            word[RD_MSB:RD_LSB]       = rd;
            word[IMM21_MSB:IMM21_LSB] = imm[20:0];
         end
         OP_G: begin
            // branch offset is word aligned, so bits [1:0] are not stored
            word[RD_MSB:RD_LSB]   = imm[6:2];
            word[RS1_MSB:RS1_LSB] = rs1;
            word[RS2_MSB:RS2_LSB] = rs2;
            word[F11_MSB:F11_LSB] = imm[17:7];
         end
         default: ;
      endcase
   end

`ifdef INSTR_ENC_RANGE_CHECK_EN
   logic fits_s16, fits_u16, fits_s18, fits_s21, fits_u21;

   // a signed N-bit value has bits [31:N-1] all equal
   assign fits_s16 = (imm[31:15] == '0) || (imm[31:15] == '1);
   assign fits_u16 = (imm[31:16] == '0);
   assign fits_s18 = (imm[31:17] == '0) || (imm[31:17] == '1);
   assign fits_s21 = (imm[31:20] == '0) || (imm[31:20] == '1);
   assign fits_u21 = (imm[31:21] == '0);

   always_comb begin
      range_fail = 1'b0;
      case (op_type_t'(op))
         OP_B, OP_F: range_fail = func3[2] ? !fits_u16 : !fits_s16;
         OP_C:       range_fail = !fits_s16;
         OP_D:       range_fail = (func3 == D_CUIR) ? !fits_u21 : !fits_s21;
         OP_G:       range_fail = !fits_s18 || (imm[1:0] != 2'b00);
         default:    range_fail = 1'b0;
      endcase
   end
`else
   logic unused_imm_hi;

   assign range_fail    = 1'b0;
   assign unused_imm_hi = ^imm[31:21];
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field bundles over valid/ready, packs them
// into ISA words and writes them sequentially into instruction memory.
//   clk, rst (sync, active-high)
//   start               : reload wr_addr to BASE_ADDR, clear word_count/full
//   in_valid/in_ready   : field bundle handshake
//   in_op..in_imm       : instruction fields
//   wr_en/wr_addr/wr_data/wr_ready : stallable memory write port
//   word_count, full    : words written since reset/start, capacity reached
//   err, err_code, err_clr : sticky error, code, and clear
// Build option: INSTR_ENC_RANGE_CHECK_EN enables immediate range errors.
//
// state   | meaning
// S_IDLE  | ready for a bundle, no write pending
// S_WRITE | word held on the write port until wr_ready
// S_ERR   | bundle rejected, waiting for err_clr
module instr_encoder
   import isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                in_op,
   input  logic [2:0]                in_func3,
   input  logic [4:0]                in_rd,
   input  logic [4:0]                in_rs1,
   input  logic [4:0]                in_rs2,
   input  logic [10:0]               in_func11,
   input  logic [31:0]               in_imm,
   output logic                      wr_en,
   output logic [31:0]               wr_addr,
   output logic [31:0]               wr_data,
   input  logic                      wr_ready,
   output logic [$clog2(MEM_WORDS):0] word_count,
   output logic                      full,
   output logic                      err,
   output logic [1:0]                err_code,
   input  logic                      err_clr
);

   localparam int unsigned     CW       = $clog2(MEM_WORDS) + 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(MEM_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ERR} state_t;

   state_t    state_q, state_d;
   err_code_t err_code_q, accept_err;
   logic      accept, write_done, start_pend, full_eff;
   logic [31:0] word;
   logic        op_illegal, range_fail;

   instr_packer u_packer (
      .op         (in_op),
      .func3      (in_func3),
      .rd         (in_rd),
      .rs1        (in_rs1),
      .rs2        (in_rs2),
      .func11     (in_func11),
      .imm        (in_imm),
      .word       (word),
      .op_illegal (op_illegal),
      .range_fail (range_fail)
   );

   // a start arriving with the bundle clears full before the overflow check
   assign full_eff = full && !start;
   assign err_code = err_code_q;

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      wr_en      = 1'b0;
      err        = 1'b0;
      accept     = 1'b0;
      accept_err = ERR_NONE;
      write_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (op_illegal)      accept_err = ERR_ILLEGAL_OP;
               else if (range_fail) accept_err = ERR_IMM_RANGE;
               else if (full_eff)   accept_err = ERR_OVERFLOW;
               state_d = (accept_err == ERR_NONE) ? S_WRITE : S_ERR;
            end
         end
         S_WRITE: begin
            wr_en = 1'b1;
            if (wr_ready) begin
               write_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_ERR: begin
            err = 1'b1;
            if (err_clr) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_addr    <= BASE_ADDR;
         wr_data    <= '0;
         word_count <= '0;
         full       <= 1'b0;
         err_code_q <= ERR_NONE;
         start_pend <= 1'b0;
      end else begin
         state_q <= state_d;

         if (accept) wr_data <= word;

         if (accept && (accept_err != ERR_NONE))
            err_code_q <= accept_err;
         else if ((state_q == S_ERR) && err_clr)
            err_code_q <= ERR_NONE;

         if (state_q == S_WRITE) begin
            // a start seen during a stalled write is deferred until it lands
            if (write_done) begin
               start_pend <= 1'b0;
               if (start || start_pend) begin
                  wr_addr    <= BASE_ADDR;
                  word_count <= '0;
                  full       <= 1'b0;
               end else begin
                  wr_addr    <= wr_addr + 32'd4;
                  word_count <= word_count + CW'(1);
                  if (word_count == LAST_CNT) full <= 1'b1;
               end
            end else if (start) begin
               start_pend <= 1'b1;
            end
         end else if (start) begin
            wr_addr    <= BASE_ADDR;
            word_count <= '0;
            full       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
   import isa_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0200;
   localparam int          MW   = 4;
   localparam int          CW   = $clog2(MW) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = '0;
   logic [2:0]    in_func3 = '0;
   logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [10:0]   in_func11 = '0;
   logic [31:0]   in_imm = '0;
   logic          wr_en;
   logic [31:0]   wr_addr, wr_data;
   logic          wr_ready = 1'b1;
   logic [CW-1:0] word_count;
   logic          full, err;
   logic [1:0]    err_code;
   logic          err_clr = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]   m_addr;
   logic [CW-1:0] m_count;
   bit            m_full;

   instr_encoder #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_func3(in_func3), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_func11(in_func11), .in_imm(in_imm),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .word_count(word_count), .full(full), .err(err), .err_code(err_code),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_encode(logic [2:0] op, logic [2:0] f3,
         logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [10:0] f11, logic [31:0] imm);
      logic [31:0] w;
      w = 32'(op) + 32'(f3) * 8;
      case (op)
         3'd0: w = w + 32'(rd) * 64 + 32'(rs1) * 2048 + 32'(rs2) * 65536 + 32'(f11) * 32'h20_0000;
         3'd1, 3'd5: w = w + 32'(rd) * 64 + 32'(rs1) * 2048 + (imm % 32'h1_0000) * 32'h1_0000;
         3'd2: w = w + (imm % 32) * 64 + 32'(rs1) * 2048 + 32'(rs2) * 65536
                   + ((imm / 32) % 2048) * 32'h20_0000;
         3'd3: w = w + 32'(rd) * 64 + (imm % 32'h20_0000) * 2048;
         3'd6: w = w + ((imm / 4) % 32) * 64 + 32'(rs1) * 2048 + 32'(rs2) * 65536
                   + ((imm / 128) % 2048) * 32'h20_0000;
         default: ;
      endcase
      return w;
   endfunction

   function automatic bit model_range_ok(logic [2:0] op, logic [2:0] f3, logic [31:0] imm);
      int s;
      s = imm;
      case (op)
         3'd1, 3'd5: return (f3 >= 3'd4) ? (imm <= 32'd65535) : (s >= -32768 && s <= 32767);
         3'd2:       return (s >= -32768 && s <= 32767);
         3'd3:       return (f3 == D_CUIR) ? (imm <= 32'd2097151) : (s >= -1048576 && s <= 1048575);
         3'd6:       return (s >= -131072 && s <= 131071) && (imm % 4 == 0);
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [1:0] model_err(logic [2:0] op, logic [2:0] f3, logic [31:0] imm);
      if (op == 3'd4 || op == 3'd7) return 2'd1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
      if (!model_range_ok(op, f3, imm)) return 2'd2;
`endif
      if (m_full) return 2'd3;
      return 2'd0;
   endfunction

   task automatic model_reload();
      m_addr  = BASE;
      m_count = '0;
      m_full  = 1'b0;
   endtask

   task automatic model_write_done();
      m_addr  = m_addr + 32'd4;
      m_count = m_count + 1'b1;
      if (m_count == CW'(MW)) m_full = 1'b1;
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [10:0] f11, input logic [31:0] imm);
      in_op = op; in_func3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_func11 = f11; in_imm = imm; in_valid = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      model_reload();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      model_reload();
      n_checks++;
      if (in_ready !== 1'b1 || wr_en !== 1'b0 || wr_addr !== BASE || wr_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_port: in_ready=%b wr_en=%b wr_addr=%h wr_data=%h, want 1 0 %h 0",
                  in_ready, wr_en, wr_addr, wr_data, BASE);
      end
      n_checks++;
      if (word_count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_status: count=%0d full=%b err=%b code=%0d, want 0 0 0 0",
                  word_count, full, err, err_code);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op  [3] = '{3'd0, 3'd1, 3'd6};
      logic [4:0]  t_rd  [3] = '{5'd1, 5'd5, 5'd0};
      logic [4:0]  t_rs1 [3] = '{5'd2, 5'd0, 5'd1};
      logic [4:0]  t_rs2 [3] = '{5'd3, 5'd0, 5'd2};
      logic [31:0] t_imm [3] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF8};
      logic [31:0] t_exp [3] = '{32'h0003_1040, 32'hFFFF_0141, 32'hFFE2_0F86};
      wr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(t_op[i], 3'd0, t_rd[i], t_rs1[i], t_rs2[i], 11'd0, t_imm[i]);
         cyc();
         in_valid = 1'b0;
         n_checks++;
         if (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_addr !== m_addr || wr_data !== t_exp[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: wr_en=%b in_ready=%b addr=%h data=%h, want 1 0 %h %h",
                     i, wr_en, in_ready, wr_addr, wr_data, m_addr, t_exp[i]);
         end
         cyc();
         model_write_done();
         n_checks++;
         if (wr_en !== 1'b0 || in_ready !== 1'b1 || word_count !== m_count || wr_addr !== m_addr) begin
            n_fail++;
            $display("FAIL directed_done_%0d: wr_en=%b in_ready=%b count=%0d addr=%h, want 0 1 %0d %h",
                     i, wr_en, in_ready, word_count, wr_addr, m_count, m_addr);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_w;
      pulse_start();
      n_checks++;
      if (word_count !== '0 || wr_addr !== BASE || full !== 1'b0) begin
         n_fail++;
         $display("FAIL start_reload: count=%0d addr=%h full=%b, want 0 %h 0", word_count, wr_addr, full, BASE);
      end
      exp_w = model_encode(3'd2, 3'd1, 5'd0, 5'd7, 5'd9, 11'd0, 32'hFFFF_FFEC);
      wr_ready = 1'b0;
      drive(3'd2, 3'd1, 5'd0, 5'd7, 5'd9, 11'd0, 32'hFFFF_FFEC);
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_addr !== m_addr || wr_data !== exp_w ||
             word_count !== m_count) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: wr_en=%b in_ready=%b addr=%h data=%h count=%0d, want 1 0 %h %h %0d",
                     i, wr_en, in_ready, wr_addr, wr_data, word_count, m_addr, exp_w, m_count);
         end
         if (i == 5) wr_ready = 1'b1;
         cyc();
      end
      model_write_done();
      n_checks++;
      if (wr_en !== 1'b0 || word_count !== m_count || wr_addr !== m_addr) begin
         n_fail++;
         $display("FAIL stall_done: wr_en=%b count=%0d addr=%h, want 0 %0d %h",
                  wr_en, word_count, wr_addr, m_count, m_addr);
      end
   endtask

   task automatic test_illegal();
      pulse_start();
      wr_ready = 1'b1;
      drive(3'b100, 3'd0, 5'd1, 5'd1, 5'd1, 11'd0, 32'd0);
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (err !== 1'b1 || err_code !== 2'd1 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_op_%0d: err=%b code=%0d wr_en=%b in_ready=%b, want 1 1 0 0",
                     i, err, err_code, wr_en, in_ready);
         end
         cyc();
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b1 || wr_addr !== m_addr) begin
         n_fail++;
         $display("FAIL illegal_clr: err=%b code=%0d in_ready=%b addr=%h, want 0 0 1 %h",
                  err, err_code, in_ready, wr_addr, m_addr);
      end
      drive(3'd3, 3'd0, 5'd4, 5'd0, 5'd0, 11'd0, 32'h0000_1234);
      cyc();
      in_valid = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== m_addr ||
          wr_data !== model_encode(3'd3, 3'd0, 5'd4, 5'd0, 5'd0, 11'd0, 32'h0000_1234)) begin
         n_fail++;
         $display("FAIL illegal_next_write: wr_en=%b addr=%h data=%h, want 1 %h", wr_en, wr_addr, wr_data, m_addr);
      end
      cyc();
      model_write_done();
   endtask

   task automatic test_overflow();
      pulse_start();
      wr_ready = 1'b1;
      for (int i = 0; i < MW; i++) begin
         drive(3'd0, 3'd2, 5'(i), 5'd3, 5'd4, 11'd5, 32'd0);
         cyc();
         in_valid = 1'b0;
         cyc();
         model_write_done();
      end
      n_checks++;
      if (full !== 1'b1 || word_count !== CW'(MW) || wr_addr !== m_addr) begin
         n_fail++;
         $display("FAIL overflow_full: full=%b count=%0d addr=%h, want 1 %0d %h", full, word_count, wr_addr, MW, m_addr);
      end
      drive(3'd0, 3'd0, 5'd1, 5'd1, 5'd1, 11'd0, 32'd0);
      cyc();
      in_valid = 1'b0;
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd3 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_err: err=%b code=%0d wr_en=%b, want 1 3 0", err, err_code, wr_en);
      end
      // start alone in ERR reloads but keeps the error
      start = 1'b1;
      cyc();
      start = 1'b0;
      model_reload();
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd3 || full !== 1'b0 || word_count !== '0 || wr_addr !== BASE) begin
         n_fail++;
         $display("FAIL start_in_err: err=%b code=%0d full=%b count=%0d addr=%h, want 1 3 0 0 %h",
                  err, err_code, full, word_count, wr_addr, BASE);
      end
      start = 1'b1;
      err_clr = 1'b1;
      cyc();
      start = 1'b0;
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b1 || word_count !== '0 || wr_addr !== BASE) begin
         n_fail++;
         $display("FAIL start_and_clr: err=%b code=%0d in_ready=%b count=%0d addr=%h, want 0 0 1 0 %h",
                  err, err_code, in_ready, word_count, wr_addr, BASE);
      end
   endtask

   task automatic test_range();
      logic [1:0] exp_code;
      pulse_start();
      wr_ready = 1'b1;
      exp_code = model_err(3'd1, 3'd0, 32'd70000);
      drive(3'd1, 3'd0, 5'd2, 5'd3, 5'd0, 11'd0, 32'd70000);
      cyc();
      in_valid = 1'b0;
      n_checks++;
      if (exp_code != 2'd0) begin
         if (err !== 1'b1 || err_code !== exp_code || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL range_b: err=%b code=%0d wr_en=%b, want 1 %0d 0", err, err_code, wr_en, exp_code);
         end
         err_clr = 1'b1;
         cyc();
         err_clr = 1'b0;
      end else begin
         if (wr_en !== 1'b1 || wr_data !== model_encode(3'd1, 3'd0, 5'd2, 5'd3, 5'd0, 11'd0, 32'd70000)) begin
            n_fail++;
            $display("FAIL range_b_trunc: wr_en=%b data=%h, want 1 %h", wr_en, wr_data,
                     model_encode(3'd1, 3'd0, 5'd2, 5'd3, 5'd0, 11'd0, 32'd70000));
         end
         cyc();
         model_write_done();
      end
   endtask

   task automatic test_start_in_write();
      logic [31:0] old_addr;
      pulse_start();
      wr_ready = 1'b1;
      drive(3'd5, 3'd4, 5'd6, 5'd7, 5'd0, 11'd0, 32'h0000_F00D);
      cyc(); in_valid = 1'b0; cyc();
      model_write_done();
      old_addr = m_addr;
      wr_ready = 1'b0;
      drive(3'd0, 3'd7, 5'd9, 5'd10, 5'd11, 11'h7FF, 32'd0);
      cyc();
      in_valid = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== old_addr) begin
         n_fail++;
         $display("FAIL start_in_write_hold: wr_en=%b addr=%h, want 1 %h", wr_en, wr_addr, old_addr);
      end
      wr_ready = 1'b1;
      cyc();
      model_reload();
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== BASE || word_count !== '0 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_write_reload: wr_en=%b addr=%h count=%0d full=%b, want 0 %h 0 0",
                  wr_en, wr_addr, word_count, full, BASE);
      end
   endtask

   task automatic test_reset_mid_write();
      wr_ready = 1'b0;
      drive(3'd3, 3'd1, 5'd1, 5'd0, 5'd0, 11'd0, 32'd99);
      cyc();
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wr_ready = 1'b1;
      model_reload();
      n_checks++;
      if (wr_en !== 1'b0 || in_ready !== 1'b1 || wr_addr !== BASE || word_count !== '0 || wr_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_write: wr_en=%b in_ready=%b addr=%h count=%0d data=%h, want 0 1 %h 0 0",
                  wr_en, in_ready, wr_addr, word_count, wr_data, BASE);
      end
   endtask

   task automatic test_random();
      logic [31:0] edges [10] = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'h0000_FFFF,
                                  32'h001F_FFFF, 32'h0010_0000, 32'hFFF0_0000, 32'h0001_FFFC,
                                  32'hFFFE_0000, 32'h0002_0000};
      for (int it = 0; it < 80; it++) begin
         logic [2:0]  op, f3;
         logic [4:0]  rd, rs1, rs2;
         logic [10:0] f11;
         logic [31:0] imm, exp_w;
         logic [1:0]  exp_code;
         int          v, stall;
         op  = 3'($urandom_range(0, 7));
         f3  = 3'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 31));
         rs1 = 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         f11 = 11'($urandom_range(0, 2047));
         v   = int'($urandom_range(0, 400)) - 200;
         case ($urandom_range(0, 3))
            0:       imm = v;
            1:       imm = $urandom();
            2:       imm = edges[$urandom_range(0, 9)];
            default: imm = v * 4;
         endcase
         if ($urandom_range(0, 5) == 0) pulse_start();
         exp_code = model_err(op, f3, imm);
         stall    = int'($urandom_range(0, 3));
         wr_ready = (stall == 0);
         drive(op, f3, rd, rs1, rs2, f11, imm);
         cyc();
         in_valid = 1'b0;
         n_checks++;
         if (exp_code != 2'd0) begin
            if (err !== 1'b1 || err_code !== exp_code || wr_en !== 1'b0) begin
               n_fail++;
               $display("FAIL rand_err it=%0d op=%0d imm=%h: err=%b code=%0d wr_en=%b, want 1 %0d 0",
                        it, op, imm, err, err_code, wr_en, exp_code);
            end
            err_clr = 1'b1;
            cyc();
            err_clr = 1'b0;
            if (exp_code == 2'd3) pulse_start();
         end else begin
            exp_w = model_encode(op, f3, rd, rs1, rs2, f11, imm);
            if (wr_en !== 1'b1 || wr_addr !== m_addr || wr_data !== exp_w) begin
               n_fail++;
               $display("FAIL rand_write it=%0d op=%0d: wr_en=%b addr=%h data=%h, want 1 %h %h",
                        it, op, wr_en, wr_addr, wr_data, m_addr, exp_w);
            end
            for (int k = 0; k < stall; k++) cyc();
            wr_ready = 1'b1;
            cyc();
            model_write_done();
            n_checks++;
            if (wr_en !== 1'b0 || word_count !== m_count || full !== m_full || wr_addr !== m_addr) begin
               n_fail++;
               $display("FAIL rand_done it=%0d: wr_en=%b count=%0d full=%b addr=%h, want 0 %0d %b %h",
                        it, wr_en, word_count, full, wr_addr, m_count, m_full, m_addr);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_illegal();
      test_overflow();
      test_range();
      test_start_in_write();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer-side counterpart of the core instruction decoder. It accepts instruction fields (op, func3, rd, rs1, rs2, func11, imm) over a valid/ready stream.
- It packs the fields into the 32-bit ISA word format and writes the words sequentially into instruction memory through a stallable write port.
- Used by the program loader and debug path to build programs in-system without a host assembler.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after reset or start.
- MEM_WORDS, 1024, instruction memory capacity in 32-bit words (power of two).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; reloads address to BASE_ADDR and clears word count and full flag.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_op  in  3  op type A..H.
- in_func3  in  3  subtype.
- in_rd / in_rs1 / in_rs2  in  5 each  register indices.
- in_func11  in  11  type A prefix.
- in_imm  in  32  signed/unsigned immediate or byte offset.
- wr_en  out  1  memory write strobe.
- wr_addr  out  32  byte address, word aligned.
- wr_data  out  32  encoded word.
- wr_ready  in  1  memory accepts write this cycle.
- word_count  out  $clog2(MEM_WORDS)+1  words written since reset/start.
- full  out  1  MEM_WORDS words written.
- err  out  1  sticky error.
- err_code  out  2  0 none, 1 illegal op, 2 imm range, 3 overflow.
- err_clr  in  1  clears err/err_code; returns to IDLE.

Behaviour:
- Word layout:
  - Common fields: op[2:0], func3[5:3].
  - A: rd[10:6], rs1[15:11], rs2[20:16], func11[31:21].
  - B, F: rd[10:6], rs1[15:11], imm16[31:16].
  - C: imm[4:0]@[10:6], rs1[15:11], rs2[20:16], imm[15:5]@[31:21].
  - D: rd[10:6], imm21[31:11].
  - G: off[6:2]@[10:6], rs1, rs2 as C, off[17:7]@[31:21].
  - Unused fields are zero.
- Reset values: state IDLE, in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, word_count=0, full=0, err=0, err_code=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, the packed word registers into wr_data.
    - Legal bundle → WRITE.
    - Illegal op (E, H) or range fail → ERR, no write.
    - full=1 at accept → ERR, code 3.
  - WRITE: in_ready=0, wr_en=1; wr_addr, wr_data held stable until wr_ready.
    - On wr_ready: wr_addr+=4, word_count+=1, full set when word_count reaches MEM_WORDS.
    - Then → IDLE, so wr_en drops the next cycle.
  - ERR: in_ready=0, wr_en=0, err=1. err_clr → IDLE with err=0, code 0; address and count are kept.
- Throughput: one word per 2 cycles with wr_ready tied high. Latency from accept to wr_en is 1 cycle.
- Range rules (macro on):
  - B/F with func3[2]=1: 0..65535. Other B/F and C: -32768..32767.
  - D: CUIR unsigned 0..2^21-1. CLIR/JLL signed 21-bit.
  - G: signed 18-bit and imm[1:0]==0.
- Boundaries:
  - wr_addr wraps to BASE_ADDR only via start. After the last word, full=1 and further accepts error with code 3.
  - start in WRITE: the pending write completes first, then the reload is applied. start in ERR reloads and keeps err.
  - start and err_clr in the same cycle: both apply.
  - rst mid-WRITE: wr_en=0 the next cycle and all state is reset.

Optional Feature:
- INSTR_ENC_RANGE_CHECK_EN.
- Defined: the range rules above apply, and a failure yields err_code 2.
- Undefined: immediates are silently truncated to the field width; only illegal op and overflow errors remain.

Decomposition:
- Shared package isa_pkg holds:
  - the op_type enum (OP_A..OP_H);
  - func3 enums for D (CLIR, CUIR, JLL) and F (LDM, JLRL);
  - field LSB/MSB position constants;
  - the err_code enum.
- The decoder imports the same package.
- Sub-module instr_packer: purely combinational field→word packing plus range-check flags; the FSM, counters and port live in instr_encoder.

Test Plan:
- A op, func3=0, rd=1, rs1=2, rs2=3, func11=0, wr_ready=1 → wr_data=0x00031040 at wr_addr=BASE_ADDR, one cycle after accept; word_count=1.
- B op, func3=0, rd=5, rs1=0, imm=-1 → 0xFFFF0141 at BASE_ADDR+4.
- G op, func3=0, rs1=1, rs2=2, imm=-8 → 0xFFE20F86.
- wr_ready held low 5 cycles during WRITE → wr_en, wr_addr, wr_data stable for 6 cycles, in_ready=0, single count increment.
- in_op=3'b100 → err=1, err_code=1, no wr_en. Then err_clr → in_ready=1 and the next legal word is written at an unchanged address.
- MEM_WORDS=4: five bundles → full=1 after 4th, 5th gives err_code=3. With INSTR_ENC_RANGE_CHECK_EN, B imm=70000 func3=0 → err_code=2.
